// File: rtl/axi_slv_bram_mem.sv
// AXI4 slave memory endpoint: INCR full-width bursts into a word array, with independent
// write (AW/W/B) and read (AR/R) engines and a 2-entry read skid for full R throughput.
module axi_slv_bram_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ID_W   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned AW_LSB = $clog2(NB);
  localparam int unsigned IDX_W  = ADDR_W - AW_LSB;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Holds ready low through the first cycle after reset release.
  logic alive_q;

  w_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]  w_id_q, w_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [8:0]       w_cnt_q, w_cnt_d;
  logic             w_err_q, w_err_d;

  r_state_e         r_state_q, r_state_d;
  logic [ID_W-1:0]  r_id_q, r_id_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [8:0]       r_fetch_q, r_fetch_d;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              fifo_wp_q, fifo_rp_q;
  logic [1:0]        fifo_cnt_q;

  logic aw_hs, w_hs, ar_hs, r_pop, fetch_en, w_last_beat;
  logic unused_addr;

  assign unused_addr = ^{awaddr[AW_LSB-1:0], araddr[AW_LSB-1:0]};

  assign awready = alive_q && (w_state_q == WIdle);
  assign wready  = (w_state_q == WData);
  assign bvalid  = (w_state_q == WResp);
  assign bid     = w_id_q;
  assign bresp   = w_err_q ? 2'b10 : 2'b00;

  assign arready = alive_q && (r_state_q == RIdle);
  assign rvalid  = (fifo_cnt_q != 2'd0);
  assign rid     = r_id_q;
  assign rdata   = fifo_data_q[fifo_rp_q];
  assign rlast   = fifo_last_q[fifo_rp_q];
  assign rresp   = 2'b00;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign ar_hs       = arvalid && arready;
  assign r_pop       = rvalid && rready;
  assign w_last_beat = (w_cnt_q == 9'd1);
  // A fetch lands in the skid at the next edge, so a full skid needs a pop this cycle.
  assign fetch_en    = (r_state_q == RData) && (r_fetch_q != 9'd0) &&
                       ((fifo_cnt_q != 2'd2) || r_pop);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    unique case (w_state_q)
      WIdle: if (aw_hs) begin
        w_id_d    = awid;
        w_idx_d   = awaddr[ADDR_W-1:AW_LSB];
        w_cnt_d   = 9'(awlen) + 9'd1;
        w_err_d   = 1'b0;
        w_state_d = WData;
      end
      WData: if (w_hs) begin
        w_cnt_d = w_cnt_q - 9'd1;
        w_idx_d = w_idx_q + IDX_W'(1);
        if (wlast != w_last_beat) w_err_d = 1'b1;
        if (w_last_beat) w_state_d = WResp;
      end
      WResp: if (bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_fetch_d = r_fetch_q;
    unique case (r_state_q)
      RIdle: if (ar_hs) begin
        r_id_d    = arid;
        r_idx_d   = araddr[ADDR_W-1:AW_LSB];
        r_fetch_d = 9'(arlen) + 9'd1;
        r_state_d = RData;
      end
      RData: begin
        if (fetch_en) begin
          r_idx_d   = r_idx_q + IDX_W'(1);
          r_fetch_d = r_fetch_q - 9'd1;
        end
        if (r_pop && rlast) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      alive_q   <= 1'b0;
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_fetch_q <= '0;
    end else begin
      alive_q   <= 1'b1;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_fetch_q <= r_fetch_d;
    end
  end

  // Memory is never cleared; reading via NBA gives read-first on same-word collisions.
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wstrb[b]) mem[w_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      if (fetch_en) begin
        fifo_data_q[fifo_wp_q] <= mem[r_idx_q];
        fifo_last_q[fifo_wp_q] <= (r_fetch_q == 9'd1);
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (r_pop) fifo_rp_q <= ~fifo_rp_q;
      if (fetch_en && !r_pop)      fifo_cnt_q <= fifo_cnt_q + 2'd1;
      else if (!fetch_en && r_pop) fifo_cnt_q <= fifo_cnt_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_axi_slv_bram_mem.sv
// Directed bench for axi_slv_bram_mem: reset, bursts, strobes, wlast error, wrap,
// stalls, concurrent channels and reset during traffic.
module tb_axi_slv_bram_mem;

  logic        aclk, aresetn;
  logic [3:0]  awid, bid, arid, rid;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] wbuf [8];
  logic [3:0]  sbuf [8];
  logic [31:0] rexp [8];

  axi_slv_bram_mem dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [11:0] addr, input int len,
                             input int bad_idx, input int bdelay, input logic [1:0] exp_resp);
    int t;
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin step(); t++; end
    check_val("awready", awready, 1);
    step();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata  = wbuf[i];
      wstrb  = sbuf[i];
      wlast  = (bad_idx < 0) ? (i == len) : (i == bad_idx);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin step(); t++; end
      check_val("wready", wready, 1);
      check_val("bvalid_early", bvalid, 0);
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check_val("bvalid_lat", bvalid, 1);
    bready = 1'b0;
    for (int i = 0; i < bdelay; i++) begin
      check_val("b_hold", {bvalid, bid, bresp}, {1'b1, id, exp_resp});
      step();
    end
    bready = 1'b1;
    check_val("bvalid", bvalid, 1);
    check_val("bid", bid, id);
    check_val("bresp", bresp, exp_resp);
    step();
    bready = 1'b0;
    check_val("awready_after_b", awready, 1);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [11:0] addr, input int len,
                            input bit rnd, input bit chk_lat);
    int t, k;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    rready = !rnd;
    t = 0;
    while (!arready && t < 50) begin step(); t++; end
    check_val("arready", arready, 1);
    step();
    arvalid = 1'b0;
    if (chk_lat) begin
      check_val("rvalid_n1", rvalid, 0);
      step();
      check_val("rvalid_n2", rvalid, 1);
    end
    k = 0;
    t = 0;
    while (k <= len && t < 300) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        check_val("rdata", rdata, rexp[k]);
        check_val("rlast", rlast, (k == len));
        check_val("rid", rid, id);
        check_val("rresp", rresp, 2'b00);
        if (rready) k++;
      end
      step();
      t++;
    end
    rready = 1'b0;
    check_val("r_beats", k, len + 1);
    if (chk_lat) check_val("r_b2b_cycles", t, len + 1);
    check_val("arready_after_r", arready, 1);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b1;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b1; rready = 1'b0;

    // Reset with AW/AR valid held high.
    repeat (4) step();
    check_val("rst_ready", {awready, wready, arready}, 3'b000);
    check_val("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    check_val("rst_bus", {bid, bresp, rid, rdata, rresp}, '0);
    aresetn = 1'b1; awvalid = 1'b0; arvalid = 1'b0;
    check_val("rel_c1_ready", {awready, arready}, 2'b00);
    step();
    check_val("rel_c2_ready", {awready, arready}, 2'b11);

    // Basic 4-beat write and back-to-back readback.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; rexp[i] = 32'hA0 + 32'(i);
    end
    write_burst(4'd3, 12'h100, 3, -1, 0, 2'b00);
    read_burst(4'd5, 12'h100, 3, 1'b0, 1'b1);

    // Byte strobes.
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    write_burst(4'd1, 12'h040, 0, -1, 0, 2'b00);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    write_burst(4'd2, 12'h040, 0, -1, 0, 2'b00);
    rexp[0] = 32'h11BB33DD;
    read_burst(4'd7, 12'h040, 0, 1'b0, 1'b1);

    // Early wlast: all beats consumed, SLVERR, data still stored.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hB0 + 32'(i); sbuf[i] = 4'hF; rexp[i] = 32'hB0 + 32'(i);
    end
    write_burst(4'd9, 12'h200, 3, 1, 0, 2'b10);
    read_burst(4'd4, 12'h200, 3, 1'b1, 1'b0);

    // Address wrap from top of memory to word 0.
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    write_burst(4'd6, 12'hFFC, 1, -1, 0, 2'b00);
    rexp[0] = 32'hC0; rexp[1] = 32'hC1;
    read_burst(4'd8, 12'hFFC, 1, 1'b0, 1'b1);
    rexp[0] = 32'hC1;
    read_burst(4'd8, 12'h000, 0, 1'b0, 1'b1);

    // Concurrent write with stalled B and random-rready read.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hD0 + 32'(i); sbuf[i] = 4'hF; rexp[i] = 32'hA0 + 32'(i);
    end
    fork
      write_burst(4'hA, 12'h300, 3, -1, 10, 2'b00);
      read_burst(4'hB, 12'h100, 3, 1'b1, 1'b0);
    join
    for (int i = 0; i < 4; i++) rexp[i] = 32'hD0 + 32'(i);
    read_burst(4'hC, 12'h300, 3, 1'b1, 1'b0);

    // Reset with a write and a stalled read in flight.
    awid = 4'd6; awaddr = 12'h380; awlen = 8'd3; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wdata = 32'hEE; wstrb = 4'hF; wvalid = 1'b1;
    repeat (2) step();
    wvalid = 1'b0;
    arid = 4'd2; araddr = 12'h300; arlen = 8'd7; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    repeat (3) step();
    check_val("stall_rvalid", rvalid, 1);
    check_val("stall_rdata", rdata, 32'hD0);
    aresetn = 1'b0;
    repeat (2) step();
    check_val("midrst_outs", {rvalid, bvalid, wready, awready, arready}, 5'b0);
    aresetn = 1'b1;
    rready = 1'b1; bready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_val("no_stale", {rvalid, bvalid}, 2'b00);
      step();
    end
    rready = 1'b0; bready = 1'b0;

    // Contents survive reset.
    for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + 32'(i);
    read_burst(4'd1, 12'h100, 3, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
